redmule_mesh_sync_ctrl: RTL and testbench
=========================================

REDMULE_MESH_SYNC_CTRL -- requirements
Module: redmule_mesh_sync_ctrl

Interface
REQ-001 SHALL have parameter N_TILES, default 4, number of mesh tiles (1..64).
REQ-002 SHALL have parameter ENABLE_WAIT, default 2, cycles between tile_enable_o rise and the first fetch_enable_o rise (0..255).
REQ-003 SHALL have parameter STAGGER_CYCLES, default 3, cycles between consecutive fetch_enable_o rises (0..255).
REQ-004 SHALL have parameter SETTLE_CYCLES, default 2, consecutive all-asleep cycles required to declare a barrier (1..255).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum wake-observation window after a barrier pulse (>=1).
REQ-006 SHALL have parameter HARTID_BASE, default 0, hart ID of tile 0.
REQ-007 clk_i  in  1  single clock; all state on its rising edge.
REQ-008 rst_ni  in  1  reset, asynchronous and active-low.
REQ-009 start_i  in  1  one-cycle request to enable and boot the masked tiles.
REQ-010 stop_i  in  1  one-cycle request to halt all tiles.
REQ-011 tile_mask_i  in  N_TILES  participating tiles; sampled only on an accepted start_i.
REQ-012 core_sleep_i  in  N_TILES  per-tile core sleep status.
REQ-013 tile_enable_o  out  N_TILES  per-tile enable.
REQ-014 fetch_enable_o  out  N_TILES  per-tile instruction fetch enable.
REQ-015 mhartid_o  out  N_TILES*32  tile i slice = HARTID_BASE+i, constant.
REQ-016 wu_wfe_o  out  N_TILES  per-tile wake-up pulse.
REQ-017 barrier_count_o  out  16  completed barriers since last accepted start_i.
REQ-018 busy_o  out  1  high in any state other than IDLE.
REQ-019 timeout_o  out  1  sticky wake-timeout error.

Function
REQ-020 SHALL implement states IDLE, ENABLE, BOOT, RUN, WAKE.
REQ-021 IDLE: start_i with tile_mask_i!=0 and stop_i low is accepted; mask registered, tile_enable_o=mask next cycle, barrier_count_o and timeout_o cleared, go to ENABLE.
REQ-022 start_i with all-zero mask, start_i together with stop_i in IDLE, and start_i in any non-IDLE state SHALL be ignored.
REQ-023 ENABLE SHALL last ENABLE_WAIT cycles, then go to BOOT.
REQ-024 For accepted start_i at cycle t, the k-th set mask bit in ascending index order (k=0,1,...) SHALL raise fetch_enable_o at cycle t+1+ENABLE_WAIT+k*STAGGER_CYCLES and hold it high; STAGGER_CYCLES=0 raises all in the same cycle.
REQ-025 BOOT SHALL go to RUN the cycle after the last masked fetch_enable_o rises; unmasked bits of tile_enable_o/fetch_enable_o/wu_wfe_o stay 0 throughout.
REQ-026 RUN: a counter SHALL count consecutive cycles where every masked core_sleep_i is high, resetting to 0 on any masked bit low; unmasked bits are ignored.
REQ-027 When the counter reaches SETTLE_CYCLES, wu_wfe_o SHALL equal the mask for exactly the next cycle, barrier_count_o SHALL increment in that same cycle (saturating at 0xFFFF), and state goes to WAKE.
REQ-028 WAKE: per-tile sticky bits SHALL record core_sleep_i low observed since the pulse; when all masked bits are set, go to RUN with the sleep counter at 0.
REQ-029 If WAKE lasts TIMEOUT_CYCLES cycles without completion, timeout_o SHALL assert, wu_wfe_o SHALL pulse once for masked tiles not yet observed awake, and the window SHALL restart; timeout_o stays high until the next accepted start_i or reset.
REQ-030 stop_i in ENABLE/BOOT/RUN/WAKE SHALL, on the next cycle, drive tile_enable_o, fetch_enable_o and wu_wfe_o to 0 and enter IDLE; barrier_count_o and timeout_o hold.
REQ-031 busy_o SHALL be registered state decode, high from cycle t+1 of accepted start_i until IDLE re-entry.

Reset
REQ-032 On rst_ni low, asynchronously: state IDLE, tile_enable_o, fetch_enable_o, wu_wfe_o, barrier_count_o, busy_o, timeout_o and all counters/sticky bits 0; mhartid_o unaffected.
REQ-033 Reset during any state, including mid-stagger or mid-pulse, SHALL abort with no further output activity until a new accepted start_i.

Verification (N_TILES=4, ENABLE_WAIT=2, STAGGER_CYCLES=3, SETTLE_CYCLES=2, TIMEOUT_CYCLES=8)
REQ-034 Boot: start_i at t with mask 4'b1011 -> tile_enable_o=1011 at t+1; fetch_enable_o bit0 at t+3, bit1 at t+6, bit3 at t+9; bit2 never; RUN at t+10.
REQ-035 Barrier: in RUN, core_sleep_i=1011 (bit2 ignored) from cycle u -> wu_wfe_o=1011 only at u+2, barrier_count_o=1 at u+2; tiles wake then re-sleep -> second pulse, count 2.
REQ-036 Glitch filter: masked sleep high for 1 cycle then one bit low -> no wu_wfe_o pulse, count unchanged.
REQ-037 Timeout: after pulse tile 3 never drops core_sleep_i -> timeout_o=1 and wu_wfe_o=1000 eight cycles after WAKE entry; tile 3 wakes -> RUN; timeout_o stays 1.
REQ-038 Stop/ignore: stop_i during BOOT after bit0 rises -> next cycle all enables 0, busy_o 0; start_i with mask 0000 or with stop_i -> no change.
REQ-039 Reset: rst_ni low in WAKE -> all outputs 0 immediately without a clock edge; mhartid_o slice i = i.

Source files
------------

// File: rtl/redmule_mesh_sync_ctrl.sv
// redmule_mesh_sync_ctrl: boots masked mesh tiles with staggered fetch enables and synchronises them on all-asleep barriers
module redmule_mesh_sync_ctrl #(
  parameter int N_TILES        = 4,
  parameter int ENABLE_WAIT    = 2,
  parameter int STAGGER_CYCLES = 3,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int HARTID_BASE    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [N_TILES-1:0]    tile_mask_i,
  input  logic [N_TILES-1:0]    core_sleep_i,
  output logic [N_TILES-1:0]    tile_enable_o,
  output logic [N_TILES-1:0]    fetch_enable_o,
  output logic [N_TILES*32-1:0] mhartid_o,
  output logic [N_TILES-1:0]    wu_wfe_o,
  output logic [15:0]           barrier_count_o,
  output logic                  busy_o,
  output logic                  timeout_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1) > 8 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CW-1:0] EW_L = CW'(ENABLE_WAIT - 1);
  localparam logic [CW-1:0] ST_L = CW'(STAGGER_CYCLES - 1);
  localparam logic [CW-1:0] SE_L = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TO_L = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, ENABLE, BOOT, RUN, WAKE} state_t;
  state_t state, state_n;
  logic [N_TILES-1:0] mask, mask_n, pending, pending_n, sticky, sticky_n;
  logic [N_TILES-1:0] tile_n, fetch_n, wu_n, src, rel;
  logic [CW-1:0] cnt, cnt_n;
  logic [15:0] bar_n;
  logic to_n, accept, asleep, awake, boot_step, halt;

  for (genvar i = 0; i < N_TILES; i++) begin : g_hart
    assign mhartid_o[i*32 +: 32] = 32'(HARTID_BASE + i);
  end

  assign accept    = state == IDLE && start_i && !stop_i && |tile_mask_i;
  assign halt      = state != IDLE && stop_i;
  assign asleep    = &(core_sleep_i | ~mask);
  assign awake     = &(sticky | ~core_sleep_i | ~mask);
  assign boot_step = STAGGER_CYCLES == 0 || cnt == ST_L;
  // Release the lowest pending tile, or every pending tile when there is no stagger
  assign src = state == IDLE ? tile_mask_i : pending;
  assign rel = STAGGER_CYCLES == 0 ? src : src & (~src + N_TILES'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= IDLE;
      busy_o          <= 1'b0;
      mask            <= '0;
      pending         <= '0;
      sticky          <= '0;
      cnt             <= '0;
      tile_enable_o   <= '0;
      fetch_enable_o  <= '0;
      wu_wfe_o        <= '0;
      barrier_count_o <= '0;
      timeout_o       <= 1'b0;
    end else begin
      state           <= state_n;
      busy_o          <= state_n != IDLE;
      mask            <= mask_n;
      pending         <= pending_n;
      sticky          <= sticky_n;
      cnt             <= cnt_n;
      tile_enable_o   <= tile_n;
      fetch_enable_o  <= fetch_n;
      wu_wfe_o        <= wu_n;
      barrier_count_o <= bar_n;
      timeout_o       <= to_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? (ENABLE_WAIT == 0 ? BOOT : ENABLE) : IDLE;
      ENABLE:  state_n = cnt == EW_L ? BOOT : ENABLE;
      BOOT:    state_n = pending == '0 ? RUN : BOOT;
      RUN:     state_n = asleep && cnt == SE_L ? WAKE : RUN;
      WAKE:    state_n = awake ? RUN : WAKE;
      default: state_n = IDLE;
    endcase
    if (halt) state_n = IDLE;
  end

  always_comb begin
    mask_n    = mask;
    pending_n = pending;
    sticky_n  = sticky;
    cnt_n     = cnt;
    tile_n    = tile_enable_o;
    fetch_n   = fetch_enable_o;
    wu_n      = '0;
    bar_n     = barrier_count_o;
    to_n      = timeout_o;
    case (state)
      IDLE: if (accept) begin
        mask_n    = tile_mask_i;
        tile_n    = tile_mask_i;
        bar_n     = '0;
        to_n      = 1'b0;
        cnt_n     = '0;
        fetch_n   = ENABLE_WAIT == 0 ? rel : '0;
        pending_n = ENABLE_WAIT == 0 ? tile_mask_i & ~rel : tile_mask_i;
      end
      ENABLE: begin
        cnt_n = cnt == EW_L ? '0 : cnt + 1'b1;
        if (cnt == EW_L) begin
          fetch_n   = fetch_enable_o | rel;
          pending_n = pending & ~rel;
        end
      end
      BOOT: begin
        cnt_n = pending == '0 || boot_step ? '0 : cnt + 1'b1;
        if (boot_step) begin
          fetch_n   = fetch_enable_o | rel;
          pending_n = pending & ~rel;
        end
      end
      RUN: begin
        cnt_n = asleep ? cnt + 1'b1 : '0;
        if (asleep && cnt == SE_L) begin
          wu_n     = mask;
          bar_n    = barrier_count_o + 16'(barrier_count_o != 16'hFFFF);
          cnt_n    = '0;
          sticky_n = '0;
        end
      end
      WAKE: begin
        sticky_n = sticky | (~core_sleep_i & mask);
        cnt_n    = awake || cnt == TO_L ? '0 : cnt + 1'b1;
        // Retry only the tiles that have not been seen awake since the barrier
        if (!awake && cnt == TO_L) begin
          to_n = 1'b1;
          wu_n = mask & ~sticky_n;
        end
      end
      default: ;
    endcase
    if (halt) begin
      tile_n    = '0;
      fetch_n   = '0;
      wu_n      = '0;
      pending_n = '0;
      cnt_n     = '0;
    end
  end
endmodule

// File: tb/tb_redmule_mesh_sync_ctrl.sv
// tb_redmule_mesh_sync_ctrl: directed vector table plus stop and reset sequences for the mesh sync controller
module tb_redmule_mesh_sync_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0;
  logic [3:0] mask = '0, sleep = '0;
  logic [3:0] tile, fetch, wu;
  logic [127:0] hart;
  logic [15:0] bar;
  logic busy, to;
  int tests = 0, fails = 0;

  typedef struct {
    logic start, stop;
    logic [3:0] mask, sleep, tile, fetch, wu;
    logic busy;
    logic [15:0] bar;
    logic to;
  } vec_t;
  vec_t v[$];

  redmule_mesh_sync_ctrl #(
    .N_TILES(4), .ENABLE_WAIT(2), .STAGGER_CYCLES(3),
    .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(8), .HARTID_BASE(0)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop),
    .tile_mask_i(mask), .core_sleep_i(sleep), .tile_enable_o(tile),
    .fetch_enable_o(fetch), .mhartid_o(hart), .wu_wfe_o(wu),
    .barrier_count_o(bar), .busy_o(busy), .timeout_o(to)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s, p, input logic [3:0] m, sl, te, fe, w,
                              input logic b, input logic [15:0] bc, input logic t);
    vec_t r;
    r.start = s; r.stop = p; r.mask = m; r.sleep = sl; r.tile = te; r.fetch = fe;
    r.wu = w; r.busy = b; r.bar = bc; r.to = t;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, p, input logic [3:0] m, sl);
    start = s; stop = p; mask = m; sleep = sl;
    step();
  endtask

  initial begin
    logic [3:0] seen;
    // boot with mask 1011: fetch bits rise at t+3, t+6, t+9; a start mid-boot is ignored
    v.push_back(mk(1, 0, 4'b1011, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 1, 0, 0));
    v.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 1, 0, 0));
    v.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b1011, 4'b0001, 4'b0000, 1, 0, 0));
    v.push_back(mk(1, 0, 4'b0100, 4'b0000, 4'b1011, 4'b0001, 4'b0000, 1, 0, 0));
    v.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b1011, 4'b0001, 4'b0000, 1, 0, 0));
    v.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b1011, 4'b0011, 4'b0000, 1, 0, 0));
    v.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b1011, 4'b0011, 4'b0000, 1, 0, 0));
    v.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b1011, 4'b0011, 4'b0000, 1, 0, 0));
    v.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b1011, 4'b1011, 4'b0000, 1, 0, 0));
    v.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b1011, 4'b1011, 4'b0000, 1, 0, 0));
    // two barriers, bit2 of sleep ignored
    v.push_back(mk(0, 0, 4'b0000, 4'b1011, 4'b1011, 4'b1011, 4'b0000, 1, 0, 0));
    v.push_back(mk(0, 0, 4'b0000, 4'b1011, 4'b1011, 4'b1011, 4'b1011, 1, 1, 0));
    v.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b1011, 4'b1011, 4'b0000, 1, 1, 0));
    v.push_back(mk(0, 0, 4'b0000, 4'b1111, 4'b1011, 4'b1011, 4'b0000, 1, 1, 0));
    v.push_back(mk(0, 0, 4'b0000, 4'b1111, 4'b1011, 4'b1011, 4'b1011, 1, 2, 0));
    v.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b1011, 4'b1011, 4'b0000, 1, 2, 0));
    // glitches: one asleep cycle then a masked bit drops
    v.push_back(mk(0, 0, 4'b0000, 4'b1011, 4'b1011, 4'b1011, 4'b0000, 1, 2, 0));
    v.push_back(mk(0, 0, 4'b0000, 4'b1001, 4'b1011, 4'b1011, 4'b0000, 1, 2, 0));
    v.push_back(mk(0, 0, 4'b0000, 4'b1011, 4'b1011, 4'b1011, 4'b0000, 1, 2, 0));
    v.push_back(mk(0, 0, 4'b0000, 4'b0011, 4'b1011, 4'b1011, 4'b0000, 1, 2, 0));
    // third barrier, tile 3 stays asleep -> timeout retry to tile 3 only
    v.push_back(mk(0, 0, 4'b0000, 4'b1011, 4'b1011, 4'b1011, 4'b0000, 1, 2, 0));
    v.push_back(mk(0, 0, 4'b0000, 4'b1011, 4'b1011, 4'b1011, 4'b1011, 1, 3, 0));
    for (int k = 0; k < 7; k++)
      v.push_back(mk(0, 0, 4'b0000, 4'b1000, 4'b1011, 4'b1011, 4'b0000, 1, 3, 0));
    v.push_back(mk(0, 0, 4'b0000, 4'b1000, 4'b1011, 4'b1011, 4'b1000, 1, 3, 1));
    v.push_back(mk(0, 0, 4'b0000, 4'b1000, 4'b1011, 4'b1011, 4'b0000, 1, 3, 1));
    v.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b1011, 4'b1011, 4'b0000, 1, 3, 1));
    v.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b1011, 4'b1011, 4'b0000, 1, 3, 1));
    // stop in RUN, then ignored starts in IDLE
    v.push_back(mk(0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 3, 1));
    v.push_back(mk(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 3, 1));
    v.push_back(mk(1, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 3, 1));

    repeat (2) step();
    check("reset tile", 32'(tile), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) check($sformatf("mhartid%0d", i), hart[i*32 +: 32], 32'(i));

    foreach (v[i]) begin
      drive(v[i].start, v[i].stop, v[i].mask, v[i].sleep);
      check($sformatf("v%0d tile", i), 32'(tile), 32'(v[i].tile));
      check($sformatf("v%0d fetch", i), 32'(fetch), 32'(v[i].fetch));
      check($sformatf("v%0d wu", i), 32'(wu), 32'(v[i].wu));
      check($sformatf("v%0d busy", i), 32'(busy), 32'(v[i].busy));
      check($sformatf("v%0d bar", i), 32'(bar), 32'(v[i].bar));
      check($sformatf("v%0d timeout", i), 32'(to), 32'(v[i].to));
    end

    // new start clears counters; stop during BOOT after bit0 rose
    drive(1, 0, 4'b1011, 4'b0000);
    check("restart tile", 32'(tile), 32'hb);
    check("restart bar", 32'(bar), 32'h0);
    check("restart timeout", 32'(to), 32'h0);
    drive(0, 0, 4'b0000, 4'b0000);
    drive(0, 0, 4'b0000, 4'b0000);
    check("boot fetch0", 32'(fetch), 32'h1);
    drive(0, 1, 4'b0000, 4'b0000);
    check("boot stop tile", 32'(tile), 32'h0);
    check("boot stop fetch", 32'(fetch), 32'h0);
    check("boot stop busy", 32'(busy), 32'h0);
    drive(0, 0, 4'b0000, 4'b0000);

    // asynchronous reset in WAKE while the barrier pulse is visible
    drive(1, 0, 4'b1011, 4'b0000);
    repeat (9) drive(0, 0, 4'b0000, 4'b0000);
    drive(0, 0, 4'b0000, 4'b1011);
    drive(0, 0, 4'b0000, 4'b1011);
    check("pre-reset wu", 32'(wu), 32'hb);
    check("pre-reset bar", 32'(bar), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async tile", 32'(tile), 32'h0);
    check("async fetch", 32'(fetch), 32'h0);
    check("async wu", 32'(wu), 32'h0);
    check("async bar", 32'(bar), 32'h0);
    check("async busy", 32'(busy), 32'h0);
    check("async timeout", 32'(to), 32'h0);
    check("async mhartid3", hart[96 +: 32], 32'h3);
    repeat (2) step();
    @(negedge clk) rst_n = 1'b1;
    seen = '0;
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 4'b0000, 4'b1011);
      seen |= tile | fetch | wu | {3'b000, busy};
    end
    check("post-reset quiet", 32'(seen), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
